vga_dram_writer: RTL and testbench
==================================

// Module: vga_dram_writer
// PURPOSE
//  Avalon-MM write master that fills an SDRAM framebuffer from a 16-bit RGB565 pixel stream.
//  Packs two pixels per 32-bit word (first pixel in [15:0]) and queues words in an internal FIFO.
//  Writes one frame of FRAME_WORDS words at ascending addresses from a base latched on start.
//  Sits between the rasteriser/blitter output and the SDRAM controller; the scan-out reader consumes its frames.
// PARAMETERS
//  FRAME_WORDS  240000  32-bit words per frame (800x600 @16bpp); counter width = clog2(FRAME_WORDS+1)
//  FIFO_AW      4       log2 of word-FIFO depth (16 words)
// PORTS
//  clk                  in   1   system clock; only clock
//  resetn               in   1   asynchronous active-low reset
//  start                in   1   1-cycle pulse: latch write_to_addr, begin a new frame
//  write_to_addr        in   32  frame base byte address, 4-byte aligned
//  pix_in               in   16  RGB565 pixel
//  pix_valid            in   1   pix_in valid
//  pix_ready            out  1   pixel accepted on an edge where pix_valid && pix_ready
//  busy                 out  1   frame in progress
//  done                 out  1   1-cycle pulse: last word of the frame accepted by the slave
//  master_address       out  32  Avalon byte address
//  master_write         out  1   Avalon write request
//  master_writedata     out  32  Avalon write data
//  master_byteenable    out  4   Avalon byte enables
//  master_waitrequest   in   1   slave stall
// BEHAVIOUR
//  Reset: master_write=0, master_address=0, master_writedata=0, master_byteenable=4'hF, pix_ready=0, busy=0, done=0;
//   FIFO, half-word latch and counters cleared; state IDLE. Reset mid-transfer abandons that transfer.
//  FSM: IDLE -start-> RUN; RUN -(2*FRAME_WORDS pixels accepted)-> FLUSH; FLUSH -(FIFO empty, no write pending)-> IDLE with done=1 for one cycle.
//  start in any state: FIFO, half-word latch and pending write discarded (master_write=0 next cycle); counters zeroed; new base latched; state RUN.
//  pix_ready = RUN && pixels_accepted < 2*FRAME_WORDS && (half-word latch empty || FIFO not full). Never high in IDLE/FLUSH.
//  Packing: even pixel goes to the half-word latch; odd pixel pushes {pix_in, latch} into the FIFO on the same edge.
//  Latency: odd pixel accepted at edge k -> master_write high in cycle k+2 (empty FIFO, idle bus).
//  Avalon: while master_write && master_waitrequest, address/writedata/byteenable/write held stable. A write is accepted on an edge with master_write && !master_waitrequest;
//   the next FIFO word is presented in the following cycle, giving 1 word/cycle sustained when waitrequest stays low.
//  Address = base + 4*words_issued, 32-bit wrap-around; words_issued saturates at FRAME_WORDS.
//  done fires on the edge that accepts word FRAME_WORDS-1; busy=0 from the next cycle. Simultaneous start and done: start wins, done suppressed.
//  Pixels offered while FIFO is full are not accepted; no pixel is ever dropped or duplicated.
// CONFIGURATION
//  VGA_DRAM_WRITER_MASK_EN defined: adds input pix_mask (1 bit, qualified by pix_valid). A masked pixel clears its half's byte enables
//   (low pixel -> [1:0], high pixel -> [3:2]). A word with both halves masked is dropped from the bus but still advances the address
//   and the word count; if it is the frame's last word, done pulses on the cycle it would have been issued.
//  Not defined: no pix_mask port; master_byteenable constant 4'hF.
// TESTING
//  FRAME_WORDS=4, start base 0x0100_0000, pixels 0x0001..0x0008, waitrequest=0 -> writes 0x0100_0000:0x0002_0001, +4:0x0004_0003,
//   +8:0x0006_0005, +C:0x0008_0007; one done pulse; busy low afterwards.
//  waitrequest high 20 cycles mid-frame with continuous pixels -> signals stable; pix_ready low after 16 words queued; written data identical after release.
//  Random pix_valid gaps and random waitrequest, FRAME_WORDS=64 -> memory model equals packed input stream; exactly 64 writes.
//  start at base 0x200 after 3 words of a frame at 0x0 -> no further writes to 0x0 range; next write to 0x200 with fresh data.
//  resetn low for 1 cycle while master_write=1 -> all outputs at reset values immediately; no write until the next start.
//  MASK_EN: masks 0,1 on a pair -> byteenable 4'b0011; masks 1,1 on the next pair -> no bus write; next word at base+8.

Source files
------------

// File: rtl/vga_dram_writer_if.sv
// Avalon-MM write-master bundle between vga_dram_writer and the SDRAM controller.
interface vga_dram_writer_if;
    logic [31:0] master_address;
    logic        master_write;
    logic [31:0] master_writedata;
    logic [3:0]  master_byteenable;
    logic        master_waitrequest;

    modport master (
        output master_address, master_write, master_writedata, master_byteenable,
        input  master_waitrequest
    );

    modport slave (
        input  master_address, master_write, master_writedata, master_byteenable,
        output master_waitrequest
    );
endinterface

// File: rtl/vga_dram_writer.sv
// Packs an RGB565 pixel stream two-per-word and writes one frame to SDRAM over Avalon-MM.
// Optional per-pixel byte masking is enabled with `define VGA_DRAM_WRITER_MASK_EN.
//
// state | meaning
// IDLE  | no frame in progress, pixels refused
// RUN   | accepting pixels until the frame's pixel count is reached
// FLUSH | all pixels taken, draining FIFO and the bus write
module vga_dram_writer #(
    parameter int FRAME_WORDS = 240000,
    parameter int FIFO_AW     = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [31:0]       write_to_addr,
    input  logic [15:0]       pix_in,
    input  logic              pix_valid,
`ifdef VGA_DRAM_WRITER_MASK_EN
    input  logic              pix_mask,
`endif
    output logic              pix_ready,
    output logic              busy,
    output logic              done,
    vga_dram_writer_if.master bus
);
    localparam int PW    = $clog2(2 * FRAME_WORDS + 1);
    localparam int WW    = $clog2(FRAME_WORDS + 1);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [PW-1:0] PIX_TOTAL   = PW'(2 * FRAME_WORDS);
    localparam logic [WW-1:0] WORDS_TOTAL = WW'(FRAME_WORDS);
    localparam logic [WW-1:0] LAST_WORD   = WW'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t             state;
    logic [31:0]        base;
    logic [PW-1:0]      pix_cnt;
    logic [WW-1:0]      words_issued;
    logic [15:0]        half_pix;
    logic               half_mask;
    logic               half_full;

    logic [31:0]        fifo_data [DEPTH];
    logic [1:0]         fifo_mask [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   fifo_cnt;

    logic               out_write;
    logic               out_last;
    logic [31:0]        out_addr;
    logic [31:0]        out_data;
    logic [3:0]         out_be;

    logic               mask_in;
    logic               fifo_full;
    logic               pix_take;
    logic               push;
    logic               slot_free;
    logic               pop;
    logic [1:0]         pop_mask;
    logic               pop_skip;
    logic               pop_is_last;
    logic               accept_last;
    logic               finish;

`ifdef VGA_DRAM_WRITER_MASK_EN
    assign mask_in = pix_mask;
`else
    assign mask_in = 1'b0;
`endif

    // fifo_cnt never exceeds DEPTH, so its top bit alone means full
    assign fifo_full   = fifo_cnt[FIFO_AW];
    assign pix_ready   = (state == RUN) && (pix_cnt < PIX_TOTAL) && (!half_full || !fifo_full);
    assign pix_take    = pix_valid && pix_ready;
    assign push        = pix_take && half_full;
    assign slot_free   = !out_write || !bus.master_waitrequest;
    assign pop         = slot_free && (fifo_cnt != '0);
    assign pop_mask    = fifo_mask[rd_ptr];
    assign pop_skip    = &pop_mask;
    assign pop_is_last = (words_issued == LAST_WORD);
    assign accept_last = out_write && !bus.master_waitrequest && out_last;
    assign finish      = accept_last || (pop && pop_skip && pop_is_last);

    assign bus.master_write      = out_write;
    assign bus.master_address    = out_addr;
    assign bus.master_writedata  = out_data;
    assign bus.master_byteenable = out_be;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= {pix_in, half_pix};
            fifo_mask[wr_ptr] <= {mask_in, half_mask};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            base         <= '0;
            pix_cnt      <= '0;
            words_issued <= '0;
            half_pix     <= '0;
            half_mask    <= 1'b0;
            half_full    <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_cnt     <= '0;
            out_write    <= 1'b0;
            out_last     <= 1'b0;
            out_addr     <= '0;
            out_data     <= '0;
            out_be       <= 4'hF;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else if (start) begin
            // a new frame abandons everything queued or pending from the old one
            state        <= RUN;
            base         <= write_to_addr;
            pix_cnt      <= '0;
            words_issued <= '0;
            half_full    <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_cnt     <= '0;
            out_write    <= 1'b0;
            out_last     <= 1'b0;
            busy         <= 1'b1;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;

            if (pix_take) begin
                pix_cnt <= pix_cnt + 1'b1;
                if (half_full) begin
                    half_full <= 1'b0;
                end else begin
                    half_pix  <= pix_in;
                    half_mask <= mask_in;
                    half_full <= 1'b1;
                end
            end

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: ;
            endcase

            // a fully masked word still consumes an address slot but never reaches the bus
            if (pop) begin
                out_write <= !pop_skip;
                out_addr  <= base + (32'(words_issued) << 2);
                out_data  <= fifo_data[rd_ptr];
                out_be    <= {{2{!pop_mask[1]}}, {2{!pop_mask[0]}}};
                out_last  <= pop_is_last;
                if (words_issued < WORDS_TOTAL) begin
                    words_issued <= words_issued + 1'b1;
                end
            end else if (slot_free) begin
                out_write <= 1'b0;
            end

            unique case (state)
                RUN: begin
                    if (pix_take && (pix_cnt == PIX_TOTAL - 1'b1)) begin
                        state <= FLUSH;
                    end
                end
                default: ;
            endcase

            if (finish) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vga_dram_writer.sv
// Bench for vga_dram_writer: a 4-word and a 64-word instance, each checked every cycle against a frame model.
`timescale 1ns/1ps
module tb_vga_dram_writer;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic        st      [2];
    logic [31:0] st_addr [2];
    logic [15:0] pin     [2];
    logic        pv      [2];
    logic        pm      [2];
    logic        wreq    [2];
    logic        pr      [2];
    logic        bz      [2];
    logic        dn      [2];
    logic        m_write [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_data  [2];
    logic [3:0]  m_be    [2];

    int checks = 0;
    int errors = 0;
    logic [31:0] log_addr [2][256];
    logic [31:0] log_data [2][256];
    logic [3:0]  log_be   [2][256];
    int log_n    [2];
    int done_cnt [2];
    int acc_cnt  [2];
    logic stream_fin;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int FW = (g == 0) ? 4 : 64;

        vga_dram_writer_if bus_i ();

        vga_dram_writer #(.FRAME_WORDS(FW), .FIFO_AW(4)) dut (
            .clk           (clk),
            .resetn        (resetn),
            .start         (st[g]),
            .write_to_addr (st_addr[g]),
            .pix_in        (pin[g]),
            .pix_valid     (pv[g]),
`ifdef VGA_DRAM_WRITER_MASK_EN
            .pix_mask      (pm[g]),
`endif
            .pix_ready     (pr[g]),
            .busy          (bz[g]),
            .done          (dn[g]),
            .bus           (bus_i)
        );

        assign bus_i.master_waitrequest = wreq[g];
        assign m_write[g] = bus_i.master_write;
        assign m_addr[g]  = bus_i.master_address;
        assign m_data[g]  = bus_i.master_writedata;
        assign m_be[g]    = bus_i.master_byteenable;

        exp_t        q[$];
        logic [31:0] base;
        int          words;
        int          pix_n;
        logic        half_v;
        logic [15:0] hp;
        logic        hm;
        logic        done_exp;
        logic        busy_exp;
        logic        prev_stall;
        logic [31:0] p_addr;
        logic [31:0] p_data;
        logic [3:0]  p_be;

        // Sampled mid-cycle: what is seen here is what the next rising edge acts on.
        always @(negedge clk) begin : model
            logic acc_last;
            logic mk;
            exp_t e;
            acc_last = 1'b0;
`ifdef VGA_DRAM_WRITER_MASK_EN
            mk = pm[g];
`else
            mk = 1'b0;
`endif
            if (!resetn) begin
                q.delete();
                words = 0; pix_n = 0; half_v = 1'b0; hp = '0; hm = 1'b0; base = '0;
                done_exp = 1'b0; busy_exp = 1'b0; prev_stall = 1'b0;
                p_addr = '0; p_data = '0; p_be = '0;
            end else begin
                if (prev_stall) begin
                    chk("hold_write", 32'(m_write[g]), 32'd1);
                    chk("hold_addr", m_addr[g], p_addr);
                    chk("hold_data", m_data[g], p_data);
                    chk("hold_be", 32'(m_be[g]), 32'(p_be));
                end
                chk("done", 32'(dn[g]), 32'(done_exp));
                chk("busy", 32'(bz[g]), 32'(busy_exp));
                if (dn[g]) done_cnt[g]++;
                if (!busy_exp || pix_n >= 2 * FW) chk("ready_gate", 32'(pr[g]), 32'd0);

                if (m_write[g] && !wreq[g]) begin
                    if (q.size() == 0) begin
                        chk("write_without_data", 32'(m_write[g]), 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("wr_addr", m_addr[g], e.addr);
                        chk("wr_data", m_data[g], e.data);
                        chk("wr_be", 32'(m_be[g]), 32'(e.be));
                        acc_last = e.last;
                    end
                    if (log_n[g] < 256) begin
                        log_addr[g][log_n[g]] = m_addr[g];
                        log_data[g][log_n[g]] = m_data[g];
                        log_be[g][log_n[g]]   = m_be[g];
                    end
                    log_n[g]++;
                end

                if (st[g]) begin
                    base = st_addr[g];
                    q.delete();
                    words = 0; pix_n = 0; half_v = 1'b0;
                    log_n[g] = 0; done_cnt[g] = 0;
                end else if (pv[g] && pr[g]) begin
                    pix_n++;
                    if (!half_v) begin
                        half_v = 1'b1; hp = pin[g]; hm = mk;
                    end else begin
                        half_v = 1'b0;
                        if (!(hm && mk)) begin
                            e.addr = base + 32'(words) * 32'd4;
                            e.data = {pin[g], hp};
                            e.be   = {{2{~mk}}, {2{~hm}}};
                            e.last = (words == FW - 1);
                            q.push_back(e);
                        end
                        words++;
                    end
                end

                done_exp   = acc_last && !st[g];
                busy_exp   = st[g] ? 1'b1 : (acc_last ? 1'b0 : busy_exp);
                prev_stall = m_write[g] && wreq[g] && !st[g];
                p_addr     = m_addr[g];
                p_data     = m_data[g];
                p_be       = m_be[g];
            end
        end
    end

    task automatic pulse_start(input int sel, input logic [31:0] b);
        st_addr[sel] = b;
        st[sel]      = 1'b1;
        acc_cnt[sel] = 0;
        @(posedge clk); #1;
        st[sel] = 1'b0;
    endtask

    task automatic stream(input int sel, input int n, input int gap_pct, input logic [15:0] v0,
                          input logic [7:0] mpat);
        int sent = 0;
        int guard = 0;
        while (sent < n && guard < 20000) begin
            if (gap_pct > 0 && $urandom_range(99) < 32'(gap_pct)) begin
                pv[sel] = 1'b0;
            end else begin
                pv[sel]  = 1'b1;
                pin[sel] = v0 + 16'(sent);
                pm[sel]  = mpat[sent % 8];
            end
            @(negedge clk);
            if (pv[sel] && pr[sel]) begin
                sent++;
                acc_cnt[sel]++;
            end
            @(posedge clk); #1;
            guard++;
        end
        pv[sel] = 1'b0;
        pm[sel] = 1'b0;
        if (sent < n) chk("stream_stall", 32'(sent), 32'(n));
    endtask

    task automatic wait_idle(input int sel, input int budget);
        int c = 0;
        @(negedge clk);
        while (bz[sel] && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (bz[sel]) chk("idle_timeout", 32'(bz[sel]), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_writes(input int sel, input int n, input int budget);
        int c = 0;
        while (log_n[sel] < n && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        if (log_n[sel] < n) chk("write_timeout", 32'(log_n[sel]), 32'(n));
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0; st_addr[i] = '0; pin[i] = '0; pv[i] = 1'b0; pm[i] = 1'b0; wreq[i] = 1'b0;
            log_n[i] = 0; done_cnt[i] = 0; acc_cnt[i] = 0;
        end
        stream_fin = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_write", 32'(m_write[i]), 32'd0);
            chk("rst_addr", m_addr[i], 32'd0);
            chk("rst_data", m_data[i], 32'd0);
            chk("rst_be", 32'(m_be[i]), 32'hF);
            chk("rst_ready", 32'(pr[i]), 32'd0);
            chk("rst_busy", 32'(bz[i]), 32'd0);
            chk("rst_done", 32'(dn[i]), 32'd0);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        // basic 4-word frame with first-write latency
        pulse_start(0, 32'h0100_0000);
        stream(0, 2, 0, 16'h0001, 8'h00);
        @(negedge clk);
        chk("latency_k1", 32'(m_write[0]), 32'd0);
        @(negedge clk);
        chk("latency_k2", 32'(m_write[0]), 32'd1);
        @(posedge clk); #1;
        stream(0, 6, 0, 16'h0003, 8'h00);
        wait_idle(0, 200);
        chk("t1_count", 32'(log_n[0]), 32'd4);
        chk("t1_a0", log_addr[0][0], 32'h0100_0000);
        chk("t1_d0", log_data[0][0], 32'h0002_0001);
        chk("t1_a1", log_addr[0][1], 32'h0100_0004);
        chk("t1_d1", log_data[0][1], 32'h0004_0003);
        chk("t1_a2", log_addr[0][2], 32'h0100_0008);
        chk("t1_d2", log_data[0][2], 32'h0006_0005);
        chk("t1_a3", log_addr[0][3], 32'h0100_000C);
        chk("t1_d3", log_data[0][3], 32'h0008_0007);
        chk("t1_done_cnt", 32'(done_cnt[0]), 32'd1);
        chk("t1_busy", 32'(bz[0]), 32'd0);

        // long stall: one word on the bus, 16 in the FIFO, one pixel latched
        wreq[1] = 1'b1;
        pulse_start(1, 32'h0000_2000);
        fork
            stream(1, 128, 0, 16'h1000, 8'h00);
            begin
                repeat (45) @(posedge clk);
                @(negedge clk);
                chk("bp_ready_low", 32'(pr[1]), 32'd0);
                chk("bp_accepted", 32'(acc_cnt[1]), 32'd35);
                chk("bp_write", 32'(m_write[1]), 32'd1);
                chk("bp_addr", m_addr[1], 32'h0000_2000);
                chk("bp_data", m_data[1], 32'h1001_1000);
                @(posedge clk); #1;
                wreq[1] = 1'b0;
            end
        join
        wait_idle(1, 300);
        chk("bp_count", 32'(log_n[1]), 32'd64);
        chk("bp_done_cnt", 32'(done_cnt[1]), 32'd1);

        // random pixel gaps and random waitrequest
        pulse_start(1, 32'h0000_4000);
        stream_fin = 1'b0;
        fork
            begin
                stream(1, 128, 30, 16'h2000, 8'h00);
                stream_fin = 1'b1;
            end
            begin
                for (int c = 0; c < 5000; c++) begin
                    if (stream_fin && !bz[1]) break;
                    wreq[1] = ($urandom_range(99) < 40);
                    @(posedge clk); #1;
                end
                wreq[1] = 1'b0;
            end
        join
        wait_idle(1, 300);
        chk("rnd_count", 32'(log_n[1]), 32'd64);
        chk("rnd_done_cnt", 32'(done_cnt[1]), 32'd1);
        chk("rnd_last_addr", log_addr[1][63], 32'h0000_40FC);

        // restart mid-frame with a pending write
        pulse_start(1, 32'h0000_0000);
        stream(1, 6, 0, 16'h3000, 8'h00);
        wait_writes(1, 3, 100);
        wreq[1] = 1'b1;
        stream(1, 4, 0, 16'h3100, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        pulse_start(1, 32'h0000_0200);
        @(negedge clk);
        chk("rs_dropped", 32'(m_write[1]), 32'd0);
        @(posedge clk); #1;
        wreq[1] = 1'b0;
        stream(1, 128, 0, 16'h4000, 8'h00);
        wait_idle(1, 300);
        chk("rs_first_addr", log_addr[1][0], 32'h0000_0200);
        chk("rs_first_data", log_data[1][0], 32'h4001_4000);
        chk("rs_count", 32'(log_n[1]), 32'd64);

`ifdef VGA_DRAM_WRITER_MASK_EN
        pulse_start(0, 32'h0000_0100);
        stream(0, 8, 0, 16'h0011, 8'b0000_1110);
        wait_idle(0, 200);
        chk("mk_count", 32'(log_n[0]), 32'd3);
        chk("mk_be0", 32'(log_be[0][0]), 32'h3);
        chk("mk_d0", log_data[0][0], 32'h0012_0011);
        chk("mk_a1", log_addr[0][1], 32'h0000_0108);
        chk("mk_a2", log_addr[0][2], 32'h0000_010C);
        chk("mk_done_cnt", 32'(done_cnt[0]), 32'd1);
`endif

        // asynchronous reset while a write is stalled on the bus
        wreq[1] = 1'b1;
        pulse_start(1, 32'h0000_8000);
        stream(1, 4, 0, 16'h5000, 8'h00);
        for (int c = 0; c < 20 && !m_write[1]; c++) @(negedge clk);
        chk("rst_pending", 32'(m_write[1]), 32'd1);
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        chk("arst_write", 32'(m_write[1]), 32'd0);
        chk("arst_addr", m_addr[1], 32'd0);
        chk("arst_data", m_data[1], 32'd0);
        chk("arst_be", 32'(m_be[1]), 32'hF);
        chk("arst_busy", 32'(bz[1]), 32'd0);
        chk("arst_ready", 32'(pr[1]), 32'd0);
        chk("arst_done", 32'(dn[1]), 32'd0);
        @(posedge clk); #1;
        resetn  = 1'b1;
        wreq[1] = 1'b0;
        repeat (10) @(negedge clk);
        chk("post_rst_write", 32'(m_write[1]), 32'd0);
        chk("post_rst_busy", 32'(bz[1]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
